// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for the unified MIPS instruction/data memory.
// Optional transfer/wait counters are enabled with `define MEM_PORT_ARBITER_STATS_EN.
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_ack,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [15:0]   r0_xfer_cnt,
  output logic [15:0]   r1_xfer_cnt,
  output logic [15:0]   wait_cnt
`endif
);

  localparam int BCW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t         state_q, state_d;
  logic           last_q, last_d;
  logic [BCW-1:0] burst_q, burst_d;
  logic           r0_gnt_q, r1_gnt_q, busy_q;
  logic [31:0]    burst_ext;
  logic           burst_hit, burst_sat;

  assign burst_ext = 32'(burst_q);
  assign burst_hit = (burst_ext + 32'd1) >= 32'(MAX_BURST);
  assign burst_sat = burst_ext >= 32'(MAX_BURST);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        burst_d = '0;
        // last_q names the previous owner, so a tie goes to the other one
        if (r0_req && (!r1_req || last_q)) state_d = OWN0;
        else if (r1_req)                   state_d = OWN1;
      end
      OWN0: begin
        if (r1_req && (!r0_req || burst_hit)) begin
          state_d = OWN1;
          burst_d = '0;
          last_d  = 1'b0;
        end else if (r0_req) begin
          burst_d = burst_sat ? burst_q : burst_q + 1'b1;
        end else begin
          state_d = IDLE;
          burst_d = '0;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (r0_req && (!r1_req || burst_hit)) begin
          state_d = OWN0;
          burst_d = '0;
          last_d  = 1'b1;
        end else if (r1_req) begin
          burst_d = burst_sat ? burst_q : burst_q + 1'b1;
        end else begin
          state_d = IDLE;
          burst_d = '0;
          last_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        burst_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      burst_q  <= '0;
      r0_gnt_q <= 1'b0;
      r1_gnt_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      burst_q  <= burst_d;
      r0_gnt_q <= (state_d == OWN0);
      r1_gnt_q <= (state_d == OWN1);
      busy_q   <= (state_d != IDLE);
    end
  end

  assign r0_gnt    = r0_gnt_q;
  assign r1_gnt    = r1_gnt_q;
  assign busy      = busy_q;
  assign r0_ack    = r0_gnt_q & r0_req & ~reset;
  assign r1_ack    = r1_gnt_q & r1_req & ~reset;
  assign mem_we    = ~reset & ((r0_gnt_q & r0_req & r0_we) | (r1_gnt_q & r1_req & r1_we));
  assign mem_addr  = r1_gnt_q ? r1_addr  : r0_addr;
  assign mem_wdata = r1_gnt_q ? r1_wdata : r0_wdata;
  assign rdata     = mem_rdata;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [15:0] r0_cnt_q, r1_cnt_q, wait_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r0_cnt_q <= '0;
      r1_cnt_q <= '0;
      wait_q   <= '0;
    end else begin
      r0_cnt_q <= r0_cnt_q + {15'd0, r0_req & r0_ack};
      r1_cnt_q <= r1_cnt_q + {15'd0, r1_req & r1_ack};
      // one tick per cycle even if both requesters are stalled
      wait_q   <= wait_q + {15'd0, (r0_req & ~r0_ack) | (r1_req & ~r1_ack)};
    end
  end

  assign r0_xfer_cnt = r0_cnt_q;
  assign r1_xfer_cnt = r1_cnt_q;
  assign wait_cnt    = wait_q;
`endif

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for the single unified instruction/data memory of the multi-cycle MIPS core.
- Requester 0 is the core's IorD address path. Requester 1 is a loader/debug port used for program load, memory inspection or a DMA engine.
- Ownership is registered, with round-robin fairness and a bounded burst length.
- Memory read is combinational and memory write is synchronous, so an acknowledged access completes in the same cycle.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_BURST, 4, maximum consecutive acknowledged accesses by one owner while the other requester is waiting (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- r0_req  in  1  requester 0 access request (valid).
- r0_we  in  1  requester 0 write enable.
- r0_addr  in  AW  requester 0 byte address.
- r0_wdata  in  DW  requester 0 write data.
- r0_gnt  out  1  requester 0 owns the memory this cycle.
- r0_ack  out  1  requester 0 access performed this cycle.
- r1_req, r1_we, r1_addr, r1_wdata  in  1/1/AW/DW  requester 1 equivalents.
- r1_gnt, r1_ack  out  1/1  requester 1 equivalents.
- rdata  out  DW  read data, equal to mem_rdata, valid when an ack is high with we=0.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory combinational read data.
- busy  out  1  state != IDLE.

Behaviour:
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), burst_cnt (ceil(log2(MAX_BURST+1)) bits).
- Reset (synchronous): state=IDLE, last_owner=1 (so r0 wins the first tie), burst_cnt=0.
  - Outputs after reset: gnt=0, ack=0, busy=0, mem_we=0, mem_addr=r0_addr.
  - While reset is high, mem_we and both acks are forced to 0 regardless of state.
- IDLE: no ack, mem_we=0, mem muxes select r0.
  - Next state: only r0_req -> OWN0; only r1_req -> OWN1; both -> OWN of !last_owner; neither -> IDLE.
- OWNx: rx_gnt=1; mem_addr/mem_wdata = rx's; mem_we = rx_req & rx_we; rx_ack = rx_req.
  - Other requester's gnt and ack are 0.
  - Transfer occurs when rx_req & rx_ack. A requester drops req after its ack to end the access. Holding req high makes one new access per cycle.
- Next state from OWNx (y = other requester):
  - If ry_req & (!rx_req | burst_cnt+1 >= MAX_BURST): go to OWNy, burst_cnt=0, last_owner=x.
  - Else if rx_req: stay in OWNx, burst_cnt=burst_cnt+1, saturating at MAX_BURST.
  - Else: go to IDLE, burst_cnt=0, last_owner=x.
- Latency and throughput:
  - Request seen in IDLE at cycle N -> gnt and ack at N+1.
  - Handover OWNx->OWNy takes zero idle cycles; ry is acked in the first OWNy cycle.
  - Sustained throughput is 1 access/cycle.
- A waiting requester gets access no later than MAX_BURST+1 cycles after asserting req.
- Requester inputs may change freely while not acked. gnt/ack are not valid in the same cycle req rises from IDLE.
- The core uses !r0_ack as its stall: its FSM holds state until it sees an ack.
- Reset mid-burst: any write in the reset cycle is suppressed, and the arbiter returns to IDLE the next cycle.

Optional Feature:
- Macro: MEM_PORT_ARBITER_STATS_EN.
- When defined, three outputs are added:
  - r0_xfer_cnt[15:0]: count of r0_req&r0_ack.
  - r1_xfer_cnt[15:0]: count of r1_req&r1_ack.
  - wait_cnt[15:0]: cycles in which some req is high and that requester has no ack.
  - All three clear on reset, wrap at 0xFFFF, and count in the cycle the event occurs.
- When not defined, these ports and counters do not exist, and all other behaviour is identical.

Test Plan:
- Single read: IDLE, r0_req=1, r0_we=0, r0_addr=0x10, mem holds 0xDEADBEEF -> cycle+1: r0_gnt=1, r0_ack=1, rdata=0xDEADBEEF, mem_we=0. After r0 drops req: IDLE next cycle.
- Tie at reset: r0_req and r1_req rise together after reset -> OWN0 first.
  - r0 holds req 10 cycles and r1 holds req, MAX_BURST=4 -> r0 acked 4 cycles, then OWN1 immediately.
  - r1 acked 4 cycles, then OWN0 again.
- Write: r1_req=1, r1_we=1, r1_addr=0x40, r1_wdata=0x12345678 -> mem_we=1 for exactly one cycle, then a read of 0x40 returns 0x12345678.
- Idle-owner handover: in OWN0, r0 drops req while r1_req=1 -> next cycle OWN1 with r1_ack=1, no IDLE cycle, last_owner=0.
- Reset mid-burst: OWN1 with r1_we=1, assert reset for 1 cycle -> mem_we=0 in that cycle, state IDLE after, busy=0.
- Stats (MEM_PORT_ARBITER_STATS_EN): the tie scenario above for 10 cycles -> r0_xfer_cnt and r1_xfer_cnt match the counted acks. wait_cnt counts the cycles r1 waited, including the initial IDLE cycle.
